// File: rtl/dmem_ctrl.sv
// dmem_ctrl: RV32I load/store unit between the cpu and a word-wide data ram.
//   Loads: LB/LH/LW/LBU/LHU with sign or zero extension from the addressed lane.
//   Stores: SW writes the full word. SB/SH read the word, merge the lane, and write it back.
//   Misaligned accesses and illegal funct3 codes finish with cpu_err and have no memory effect.
//   Optional feature macro: DMEM_MMIO_EN adds a word-wide output register at MMIO_ADDR.
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   cpu_req/we/funct3/addr      request, sampled only while idle
//   cpu_wr_data, cpu_rd_data    store data in, extended load data out
//   cpu_ready, cpu_err          one-cycle completion pulse, with error flag
//   ram_addr/wr_sig/wr_data     word address, write strobe, write word
//   ram_rd_data                 read word, one cycle after ram_addr
//   mmio_out                    output register (0 without DMEM_MMIO_EN)
module dmem_ctrl #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] MMIO_ADDR  = 32'hFFFF_FFF0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [2:0]            cpu_funct3,
  input  logic [31:0]           cpu_addr,
  input  logic [31:0]           cpu_wr_data,
  output logic [31:0]           cpu_rd_data,
  output logic                  cpu_ready,
  output logic                  cpu_err,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_wr_sig,
  output logic [31:0]           ram_wr_data,
  input  logic [31:0]           ram_rd_data,
  output logic [31:0]           mmio_out
);

  typedef enum logic [2:0] {IDLE, RD_WAIT, WR, MERGE_WR, ERR, DONE} state_t;

  state_t                state, state_next;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [31:0]           data_q;   // store word, merged word, or load result
  logic                  mmio_q;

  // Request decode (only meaningful while idle)
  logic mmio_word_hit, mmio_sub_hit, req_err;
  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu_addr[31:ADDR_WIDTH+2];

`ifdef DMEM_MMIO_EN
  assign mmio_word_hit = (cpu_addr == MMIO_ADDR) && (cpu_funct3 == 3'b010);
  assign mmio_sub_hit  = (cpu_addr[31:2] == MMIO_ADDR[31:2]) && (cpu_funct3 != 3'b010);
`else
  assign mmio_word_hit = 1'b0;
  assign mmio_sub_hit  = 1'b0;
`endif

  always_comb begin
    req_err = 1'b0;
    case (cpu_funct3)
      3'b000, 3'b100: req_err = 1'b0;
      3'b001, 3'b101: req_err = cpu_addr[0];
      3'b010:         req_err = (cpu_addr[1:0] != 2'b00);
      default:        req_err = 1'b1;
    endcase
    // BU/HU encodings have no store counterpart
    if (cpu_we && cpu_funct3[2]) req_err = 1'b1;
    if (mmio_sub_hit)            req_err = 1'b1;
  end

  // Lane extraction (loads) and lane merge (sub-word stores)
  logic [31:0] src_word, byte_sh, half_sh, load_val, lane_mask, lane_data, merged;

  always_comb begin
    src_word  = mmio_q ? mmio_out : ram_rd_data;
    byte_sh   = src_word >> {addr_q[1:0], 3'b000};
    half_sh   = src_word >> {addr_q[1], 4'b0000};
    case (f3_q)
      3'b000:  load_val = {{24{byte_sh[7]}}, byte_sh[7:0]};
      3'b100:  load_val = {24'h0, byte_sh[7:0]};
      3'b001:  load_val = {{16{half_sh[15]}}, half_sh[15:0]};
      3'b101:  load_val = {16'h0, half_sh[15:0]};
      default: load_val = src_word;
    endcase
    if (f3_q[0]) begin
      lane_mask = 32'h0000_FFFF << {addr_q[1], 4'b0000};
      lane_data = {2{data_q[15:0]}};
    end else begin
      lane_mask = 32'h0000_00FF << {addr_q[1:0], 3'b000};
      lane_data = {4{data_q[7:0]}};
    end
    merged = (ram_rd_data & ~lane_mask) | (lane_data & lane_mask);
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          if (req_err)                            state_next = ERR;
          else if (cpu_we && cpu_funct3 == 3'b010) state_next = WR;
          else                                    state_next = RD_WAIT;
        end
      end
      RD_WAIT:       state_next = we_q ? MERGE_WR : DONE;
      WR, MERGE_WR:  state_next = DONE;
      ERR, DONE:     state_next = IDLE;
      default:       state_next = IDLE;
    endcase
  end

  // State and datapath registers
  // NOTE: only state, the result register and mmio_out are reset; the captured
  // request fields are don't-care until the next accept overwrites them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      data_q <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (cpu_req) begin
          we_q   <= cpu_we;
          f3_q   <= cpu_funct3;
          addr_q <= cpu_addr[ADDR_WIDTH+1:0];
          data_q <= cpu_we ? cpu_wr_data : 32'h0;
          mmio_q <= mmio_word_hit;
        end
        RD_WAIT: data_q <= we_q ? merged : load_val;
        default: ;
      endcase
    end
  end

`ifdef DMEM_MMIO_EN
  always_ff @(posedge clk) begin
    if (reset)                      mmio_out <= '0;
    else if (state == WR && mmio_q) mmio_out <= data_q;
  end
`else
  assign mmio_out = '0;
`endif

  // Outputs. The ram address follows the live request while idle so the read
  // data is already valid in RD_WAIT; the write strobe is masked by reset so an
  // interrupted read-modify-write never reaches the ram.
  assign ram_addr    = (state == IDLE) ? cpu_addr[ADDR_WIDTH+1:2] : addr_q[ADDR_WIDTH+1:2];
  assign ram_wr_data = data_q;
  assign ram_wr_sig  = !reset && ((state == MERGE_WR) || (state == WR && !mmio_q));
  assign cpu_ready   = (state == DONE) || (state == ERR);
  assign cpu_err     = (state == ERR);
  assign cpu_rd_data = (state == DONE && !we_q) ? data_q : 32'h0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: self-checking bench for dmem_ctrl. A behavioural ram sits on the
// ram port; a byte-addressed reference memory predicts every load result,
// latency, error flag and write count, and the final ram image.
module tb_dmem_ctrl;

  localparam int          AW   = 10;
  localparam logic [31:0] MMIO = 32'hFFFF_FFF0;
  localparam int          NBYTES = 4 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [2:0]    cpu_funct3 = 3'b0;
  logic [31:0]   cpu_addr = '0;
  logic [31:0]   cpu_wr_data = '0;
  logic [31:0]   cpu_rd_data;
  logic          cpu_ready, cpu_err;
  logic [AW-1:0] ram_addr;
  logic          ram_wr_sig;
  logic [31:0]   ram_wr_data;
  logic [31:0]   ram_rd_data;
  logic [31:0]   mmio_out;

  int errors = 0;
  int checks = 0;

  bit [31:0] tb_ram   [0:(1<<AW)-1];
  bit [7:0]  ref_bytes[0:NBYTES-1];
  logic [31:0] exp_mmio = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr_sig) tb_ram[ram_addr] <= ram_wr_data;
    ram_rd_data <= tb_ram[ram_addr];
  end

  dmem_ctrl #(.ADDR_WIDTH(AW), .MMIO_ADDR(MMIO)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_funct3(cpu_funct3), .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data),
    .cpu_rd_data(cpu_rd_data), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
    .ram_addr(ram_addr), .ram_wr_sig(ram_wr_sig), .ram_wr_data(ram_wr_data),
    .ram_rd_data(ram_rd_data), .mmio_out(mmio_out)
  );

  function automatic logic [31:0] ref_word(input logic [31:0] addr);
    int b;
    b = int'(addr[AW+1:2]) * 4;
    return {ref_bytes[b+3], ref_bytes[b+2], ref_bytes[b+1], ref_bytes[b]};
  endfunction

  // Reference model: predicts the outcome of one access and applies its effect.
  task automatic ref_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, output logic e_err, output logic [31:0] e_rd,
                            output int e_lat, output int e_wr);
    int  b;
    logic mmio_hit, mmio_near;
    b = int'(addr[AW+1:0]);
    mmio_near = 1'b0;
`ifdef DMEM_MMIO_EN
    mmio_near = (addr[31:2] == MMIO[31:2]);
`endif
    mmio_hit = mmio_near && (f3 == 3'd2);
    e_err = (f3 == 3'd3) || (f3 >= 3'd6) || (we && f3 >= 3'd4) ||
            ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) ||
            (f3 == 3'd2 && addr[1:0] != 2'b00) || (mmio_near && f3 != 3'd2);
    e_rd = 32'h0; e_lat = 1; e_wr = 0;
    if (e_err) return;
    if (we) begin
      e_lat = (f3 == 3'd2) ? 2 : 3;
      e_wr  = mmio_hit ? 0 : 1;
      if (mmio_hit) exp_mmio = wd;
      else begin
        for (int i = 0; i < (1 << f3[1:0]); i++) ref_bytes[b+i] = wd[8*i +: 8];
      end
    end else begin
      e_lat = 2;
      case (f3)
        3'd0: e_rd = 32'($signed(ref_bytes[b]));
        3'd4: e_rd = 32'(ref_bytes[b]);
        3'd1: e_rd = 32'($signed({ref_bytes[b+1], ref_bytes[b]}));
        3'd5: e_rd = 32'({ref_bytes[b+1], ref_bytes[b]});
        default: e_rd = mmio_hit ? exp_mmio : ref_word(addr);
      endcase
    end
  endtask

  // Issues one access in an idle cycle and compares everything observable.
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input string name);
    logic        e_err, g_err;
    logic [31:0] e_rd, g_rd;
    int          e_lat, e_wr, g_lat, g_wr;
    ref_access(we, f3, addr, wd, e_err, e_rd, e_lat, e_wr);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_funct3 = f3; cpu_addr = addr; cpu_wr_data = wd;
    g_lat = 0; g_wr = 0; g_err = 1'bx; g_rd = 'x;
    for (int k = 1; k <= 8 && g_lat == 0; k++) begin
      @(negedge clk);
      cpu_req = 1'b0;
      if (ram_wr_sig) g_wr++;
      if (cpu_ready) begin g_lat = k; g_rd = cpu_rd_data; g_err = cpu_err; end
    end
    checks += 5;
    if (g_lat !== e_lat) begin errors++; $display("FAIL %s latency: got %0d expected %0d", name, g_lat, e_lat); end
    if (g_err !== e_err) begin errors++; $display("FAIL %s cpu_err: got %b expected %b", name, g_err, e_err); end
    if (g_rd !== e_rd)   begin errors++; $display("FAIL %s rd_data: got %h expected %h", name, g_rd, e_rd); end
    if (g_wr !== e_wr)   begin errors++; $display("FAIL %s ram writes: got %0d expected %0d", name, g_wr, e_wr); end
    if (mmio_out !== exp_mmio) begin errors++; $display("FAIL %s mmio_out: got %h expected %h", name, mmio_out, exp_mmio); end
  endtask

  task automatic check_ram_word(input int idx, input logic [31:0] exp, input string name);
    checks++;
    if (tb_ram[idx] !== exp) begin
      errors++; $display("FAIL %s ram[%0d]: got %h expected %h", name, idx, tb_ram[idx], exp);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks += 5;
    if (cpu_ready !== 1'b0)   begin errors++; $display("FAIL reset cpu_ready: got %b expected 0", cpu_ready); end
    if (cpu_err !== 1'b0)     begin errors++; $display("FAIL reset cpu_err: got %b expected 0", cpu_err); end
    if (cpu_rd_data !== 32'h0) begin errors++; $display("FAIL reset rd_data: got %h expected 0", cpu_rd_data); end
    if (ram_wr_sig !== 1'b0)  begin errors++; $display("FAIL reset ram_wr_sig: got %b expected 0", ram_wr_sig); end
    if (mmio_out !== 32'h0)   begin errors++; $display("FAIL reset mmio_out: got %h expected 0", mmio_out); end
  endtask

  task automatic test_word;
    run_op(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, "sw_0x10");
    run_op(1'b0, 3'd2, 32'h10, 32'h0, "lw_0x10");
    check_ram_word(4, 32'hDEADBEEF, "sw_word");
  endtask

  task automatic test_loads;
    run_op(1'b0, 3'd0, 32'h13, 32'h0, "lb_0x13");
    run_op(1'b0, 3'd4, 32'h13, 32'h0, "lbu_0x13");
    run_op(1'b0, 3'd1, 32'h10, 32'h0, "lh_0x10");
    run_op(1'b0, 3'd5, 32'h12, 32'h0, "lhu_0x12");
  endtask

  task automatic test_rmw;
    run_op(1'b1, 3'd0, 32'h11, 32'hFFFF_FF55, "sb_0x11");
    check_ram_word(4, 32'hDEAD55EF, "sb_merge");
    run_op(1'b1, 3'd1, 32'h12, 32'hABCD_1234, "sh_0x12");
    check_ram_word(4, 32'h123455EF, "sh_merge");
  endtask

  task automatic test_errors;
    run_op(1'b0, 3'd2, 32'h12, 32'h0, "lw_misaligned");
    run_op(1'b1, 3'd1, 32'h01, 32'hFFFF, "sh_misaligned");
    run_op(1'b0, 3'd3, 32'h10, 32'h0, "funct3_011");
    run_op(1'b1, 3'd4, 32'h10, 32'h77, "store_bu");
    run_op(1'b1, 3'd6, 32'h10, 32'h77, "funct3_110");
    run_op(1'b1, 3'd2, 32'h13, 32'h1, "sw_misaligned");
    check_ram_word(4, 32'h123455EF, "err_no_effect");
  endtask

  task automatic test_reset_abort;
    int wr_seen;
    wr_seen = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_funct3 = 3'd0; cpu_addr = 32'h11; cpu_wr_data = 32'hAA;
    @(negedge clk);
    cpu_req = 1'b0;
    reset = 1'b1;
    if (ram_wr_sig) wr_seen++;
    @(negedge clk);
    if (ram_wr_sig) wr_seen++;
    reset = 1'b0;
    exp_mmio = '0;
    checks += 2;
    if (wr_seen != 0) begin errors++; $display("FAIL abort ram writes: got %0d expected 0", wr_seen); end
    if (cpu_ready !== 1'b0) begin errors++; $display("FAIL abort cpu_ready: got %b expected 0", cpu_ready); end
    check_ram_word(4, 32'h123455EF, "abort_ram");
    run_op(1'b0, 3'd2, 32'h10, 32'h0, "lw_after_abort");
  endtask

  task automatic test_alias;
    run_op(1'b1, 3'd2, 32'h10 + NBYTES, 32'hCAFE_F00D, "sw_alias");
    run_op(1'b0, 3'd2, 32'h8000_0010, 32'h0, "lw_alias");
    run_op(1'b1, 3'd2, MMIO, 32'h55, "sw_mmio_addr");
    run_op(1'b0, 3'd2, MMIO, 32'h0, "lw_mmio_addr");
    run_op(1'b1, 3'd0, MMIO + 1, 32'h66, "sb_mmio_addr");
    run_op(1'b0, 3'd4, MMIO + 1, 32'h0, "lbu_mmio_addr");
  endtask

  task automatic test_back_to_back;
    logic [31:0] a, d;
    logic [2:0]  f3;
    logic        we;
    for (int n = 0; n < 300; n++) begin
      a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      d  = $urandom;
      f3 = 3'($urandom_range(0, 7));
      we = 1'($urandom_range(0, 1));
      run_op(we, f3, a, d, $sformatf("rand%0d", n));
    end
  endtask

  task automatic test_final_image;
    int bad;
    bad = 0;
    for (int i = 0; i < (1 << AW); i++) begin
      if (tb_ram[i] !== ref_word(32'(i * 4))) begin
        bad++;
        if (bad <= 4) $display("FAIL image ram[%0d]: got %h expected %h", i, tb_ram[i], ref_word(32'(i * 4)));
      end
    end
    checks++;
    if (bad != 0) errors++;
  endtask

  initial begin
    test_reset;
    test_word;
    test_loads;
    test_rmw;
    test_errors;
    test_reset_abort;
    test_alias;
    test_back_to_back;
    test_final_image;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
